// File: rtl/fma16.sv
// Half-precision fused multiply-add: operands are aligned exactly on a wide fixed-point
// grid, summed, then rounded once. A sticky register accumulates the exception flags.
module fma16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic [3:0]  flags_sticky
);
  // Grid LSB is 2^-48 (smallest product ulp); the largest product needs bit 80.
  localparam int W = 82;
  localparam logic [15:0] QNAN = 16'h7e00;

  typedef enum logic [1:0] {RZ = 2'b00, RNE = 2'b01, RD = 2'b10, RU = 2'b11} rmode_e;

  function automatic logic [10:0] sig_of(input logic [14:0] v);
    return {|v[14:10], v[9:0]};
  endfunction

  function automatic logic [6:0] exp_of(input logic [4:0] e);
    return (e == 5'd0) ? 7'd1 : {2'b00, e};
  endfunction

  function automatic logic is_nan(input logic [14:0] v);
    return (&v[14:10]) && (|v[9:0]);
  endfunction

  function automatic logic is_inf(input logic [14:0] v);
    return (&v[14:10]) && (v[9:0] == 10'd0);
  endfunction

  rmode_e       rm;
  logic [15:0]  yv;
  logic         sp, sz, sgn, zsgn;
  logic         any_nan, any_snan, x_inf, y_inf, z_inf, p_inf, x_zero, y_zero, inv, ovf_inf;
  logic [21:0]  prod;
  logic [W-1:0] pa, za, sum;
  logic [6:0]   p, sh;
  logic [11:0]  kept;
  logic         guard, sticky, inexact, inc;
  logic [16:0]  enc;
  logic [3:0]   flags_sticky_q, flags_sticky_d;

  assign rm = rmode_e'(roundmode);
  assign yv = mul ? y : 16'h3c00;
  assign sp = x[15] ^ yv[15] ^ negp;
  // With no addend, z takes the product's sign so a zero product keeps its own sign.
  assign sz = add ? (z[15] ^ negz) : sp;

  assign any_nan  = is_nan(x[14:0]) | is_nan(yv[14:0]) | (add & is_nan(z[14:0]));
  assign any_snan = (is_nan(x[14:0]) & ~x[9]) | (is_nan(yv[14:0]) & ~yv[9])
                  | (add & is_nan(z[14:0]) & ~z[9]);
  assign x_inf    = is_inf(x[14:0]);
  assign y_inf    = is_inf(yv[14:0]);
  assign z_inf    = add & is_inf(z[14:0]);
  assign p_inf    = x_inf | y_inf;
  assign x_zero   = (x[14:0] == 15'd0);
  assign y_zero   = (yv[14:0] == 15'd0);
  assign inv      = (x_inf & y_zero) | (x_zero & y_inf) | (p_inf & z_inf & (sp != sz));

  assign prod = 22'(sig_of(x[14:0])) * 22'(sig_of(yv[14:0]));
  assign pa   = W'(prod) << (exp_of(x[14:10]) + exp_of(yv[14:10]) - 7'd2);
  assign za   = add ? (W'(sig_of(z[14:0])) << (exp_of(z[14:10]) + 7'd23)) : '0;
  assign zsgn = (sp == sz) ? sp : (rm == RD);

  // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
  always_comb begin
    sum = '0;
    sgn = sp;
    if (sp == sz)      sum = pa + za;
    else if (pa >= za) sum = pa - za;
    else begin
      sum = za - pa;
      sgn = sz;
    end
  end

  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) if (sum[i]) p = 7'(i);
  end

  // Keep 11 bits below the leading one, but never below the subnormal ulp (grid bit 24).
  always_comb begin
    sh      = (p >= 7'd34) ? p - 7'd10 : 7'd24;
    kept    = 12'(sum >> sh);
    guard   = sum[sh - 7'd1];
    sticky  = |(sum & ((W'(1) << (sh - 7'd1)) - W'(1)));
    inexact = guard | sticky;
    unique case (rm)
      RNE:     inc = guard & (sticky | kept[0]);
      RD:      inc = sgn & inexact;
      RU:      inc = ~sgn & inexact;
      default: inc = 1'b0;
    endcase
    // Exponent field plus significand with hidden bit: a rounding carry bumps the exponent.
    enc = (17'(sh - 7'd24) << 10) + 17'(kept) + 17'(inc);
  end

  assign ovf_inf = (rm == RNE) | ((rm == RD) & sgn) | ((rm == RU) & ~sgn);

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    result = {sgn, enc[14:0]};
    flags  = {2'b00, inexact & (enc < 17'h0400), inexact};
    if (any_nan) begin
      result = QNAN;
      flags  = {any_snan, 3'b000};
    end else if (inv) begin
      result = QNAN;
      flags  = 4'b1000;
    end else if (p_inf | z_inf) begin
      result = {p_inf ? sp : sz, 15'h7c00};
      flags  = 4'b0000;
    end else if (sum == '0) begin
      result = {zsgn, 15'h0000};
      flags  = 4'b0000;
    end else if (enc >= 17'h7c00) begin
      result = {sgn, ovf_inf ? 15'h7c00 : 15'h7bff};
      flags  = 4'b0101;
    end
  end

  assign flags_sticky_d = flags_sticky_q | flags;

  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_sticky_q <= '0;
    else       flags_sticky_q <= flags_sticky_d;
  end

  assign flags_sticky = flags_sticky_q;
endmodule

// File: tb/tb_fma16.sv
// Bench for fma16: directed vectors, randomized operands against an exact-value
// reference model, and sticky-flag accumulation across back-to-back operations.
module tb_fma16;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y, z;
  logic        mul, add, negp, negz;
  logic [1:0]  roundmode;
  logic [15:0] result;
  logic [3:0]  flags, flags_sticky;
  int          n_tests = 0;
  int          n_fail  = 0;

  fma16 dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .z(z), .mul(mul), .add(add),
    .negp(negp), .negz(negz), .roundmode(roundmode),
    .result(result), .flags(flags), .flags_sticky(flags_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x, y, z;
    logic        mul, add, negp, negz;
    logic [1:0]  rm;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  // Magnitude of an encoding in units of 2^-48; bits [15:10] act as an unbounded exponent.
  function automatic logic [255:0] hval(input logic [15:0] e);
    logic [5:0]  ex;
    logic [10:0] m;
    ex = e[15:10];
    m  = {ex != 6'd0, e[9:0]};
    return 256'(m) << (((ex == 6'd0) ? 1 : int'(ex)) + 23);
  endfunction

  function automatic logic isnan(input logic [15:0] h);
    return (h[14:10] == 5'h1f) && (h[9:0] != 10'd0);
  endfunction

  function automatic logic isinf(input logic [15:0] h);
    return (h[14:10] == 5'h1f) && (h[9:0] == 10'd0);
  endfunction

  task automatic model(input logic [15:0] xi, yi, zi, input logic mi, ai, npi, nzi,
                       input logic [1:0] rm, output logic [15:0] r, output logic [3:0] f);
    logic [15:0]         yo;
    logic                sp, sz, neg, snan_in, xinf, yinf, zinf, xz, yz, inexact;
    logic signed [255:0] v;
    logic [255:0]        mag, lo_v, hi_v, zm;
    int                  lo, hi, mid, rr;
    yo      = mi ? yi : 16'h3c00;
    sp      = xi[15] ^ yo[15] ^ npi;
    sz      = zi[15] ^ nzi;
    snan_in = (isnan(xi) && !xi[9]) || (isnan(yo) && !yo[9]) || (ai && isnan(zi) && !zi[9]);
    xinf    = isinf(xi);
    yinf    = isinf(yo);
    zinf    = ai && isinf(zi);
    xz      = (xi[14:0] == 15'd0);
    yz      = (yo[14:0] == 15'd0);
    r = 16'h0000;
    f = 4'b0000;
    if (isnan(xi) || isnan(yo) || (ai && isnan(zi))) begin
      r = 16'h7e00; f = {snan_in, 3'b000};
    end else if ((xinf && yz) || (xz && yinf) || ((xinf || yinf) && zinf && sp != sz)) begin
      r = 16'h7e00; f = 4'b1000;
    end else if (xinf || yinf) begin
      r = {sp, 15'h7c00};
    end else if (zinf) begin
      r = {sz, 15'h7c00};
    end else begin
      v = $signed((hval({1'b0, xi[14:0]}) * hval({1'b0, yo[14:0]})) >> 48);
      if (sp) v = -v;
      if (ai) begin
        zm = hval({1'b0, zi[14:0]});
        v  = sz ? v - $signed(zm) : v + $signed(zm);
      end
      if (v == 0) begin
        neg = !ai ? sp : ((sp == sz) ? sp : (rm == 2'b10));
        r   = {neg, 15'h0000};
      end else begin
        neg = (v < 0);
        mag = neg ? -v : v;
        lo = 0; hi = 65535;
        while (lo < hi) begin
          mid = (lo + hi + 1) / 2;
          if (hval(16'(mid)) <= mag) lo = mid; else hi = mid - 1;
        end
        lo_v    = hval(16'(lo));
        hi_v    = hval(16'(lo + 1));
        inexact = (lo_v != mag);
        rr      = lo;
        if (inexact) begin
          case (rm)
            2'b01: if ((mag - lo_v > hi_v - mag) || ((mag - lo_v == hi_v - mag) && (lo % 2 == 1)))
                     rr = lo + 1;
            2'b10: if (neg)  rr = lo + 1;
            2'b11: if (!neg) rr = lo + 1;
            default: rr = lo;
          endcase
        end
        if (rr > 32'h7bff) begin
          f = 4'b0101;
          case (rm)
            2'b00:   r = {neg, 15'h7bff};
            2'b01:   r = {neg, 15'h7c00};
            2'b10:   r = neg ? 16'hfc00 : 16'h7bff;
            default: r = neg ? 16'hfbff : 16'h7c00;
          endcase
        end else begin
          r = {neg, 15'(rr)};
          f = {2'b00, inexact && (rr < 32'h0400), inexact};
        end
      end
    end
  endtask

  function automatic logic [15:0] rand_half();
    int k;
    k = int'($urandom_range(0, 9));
    case (k)
      0, 1, 2: return 16'($urandom);
      3, 4, 5: return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
      6, 7:    return {1'($urandom), 5'($urandom_range(0, 4)), 10'($urandom)};
      default: begin
        case ($urandom_range(0, 7))
          0:       return 16'h0000;
          1:       return 16'h8000;
          2:       return 16'h7c00;
          3:       return 16'hfc00;
          4:       return 16'h7e00;
          5:       return 16'h7d01;
          6:       return 16'h7bff;
          default: return 16'h0001;
        endcase
      end
    endcase
  endfunction

  task automatic drive(input logic [15:0] xi, yi, zi, input logic mi, ai, npi, nzi,
                       input logic [1:0] rm);
    x = xi; y = yi; z = zi; mul = mi; add = ai; negp = npi; negz = nzi; roundmode = rm;
  endtask

  task automatic random_op(output logic [15:0] xi, yi, zi, output logic mi, ai, npi, nzi,
                           output logic [1:0] rm);
    logic [15:0] er;
    logic [3:0]  ef;
    xi  = rand_half(); yi = rand_half(); zi = rand_half();
    mi  = ($urandom_range(0, 7) != 0);
    ai  = ($urandom_range(0, 3) != 0);
    npi = 1'($urandom); nzi = 1'($urandom); rm = 2'($urandom);
    if (ai && $urandom_range(0, 3) == 0) begin
      // Addend close to the negated rounded product forces deep cancellation.
      model(xi, yi, 16'h0000, mi, 1'b0, npi, 1'b0, rm, er, ef);
      zi  = (er ^ 16'h8000) ^ 16'($urandom_range(0, 3));
      nzi = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(16'h7bff, 16'h7bff, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (flags_sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_sticky: got %b want 0000", flags_sticky);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t vecs [0:21];
    vecs = '{
      '{16'h3c00, 16'h3c00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h3c00, 4'b0000},
      '{16'h3c00, 16'h3c00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 16'hbc00, 4'b0000},
      '{16'h4000, 16'h4200, 16'h3c00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h4700, 4'b0000},
      '{16'h4000, 16'h4200, 16'h3c00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'h4500, 4'b0000},
      '{16'h3c01, 16'h3c01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h3c02, 4'b0001},
      '{16'h3c01, 16'h3c01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h3c03, 4'b0001},
      '{16'h3c01, 16'h3c01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h3c02, 4'b0001},
      '{16'h7bff, 16'h7bff, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7c00, 4'b0101},
      '{16'h7bff, 16'h7bff, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h7bff, 4'b0101},
      '{16'h7bff, 16'h7bff, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 16'hfbff, 4'b0101},
      '{16'h7bff, 16'h7bff, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 16'hfc00, 4'b0101},
      '{16'h7c00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7e00, 4'b1000},
      '{16'h7c00, 16'h3c00, 16'hfc00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h7e00, 4'b1000},
      '{16'h7e00, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h7e00, 4'b0000},
      '{16'h3c00, 16'h3c00, 16'hbc00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0000, 4'b0000},
      '{16'h3c00, 16'h3c00, 16'hbc00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 16'h8000, 4'b0000},
      '{16'h0001, 16'h3c00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0001, 4'b0000},
      '{16'h0001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0000, 4'b0011},
      '{16'h0001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0001, 4'b0011},
      '{16'h4248, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 16'h4248, 4'b0000},
      '{16'h7d00, 16'h3c00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7e00, 4'b1000},
      '{16'h4000, 16'h4000, 16'h7e00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h4400, 4'b0000}
    };
    foreach (vecs[i]) begin
      drive(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].mul, vecs[i].add,
            vecs[i].negp, vecs[i].negz, vecs[i].rm);
      #1;
      n_tests++;
      if (result !== vecs[i].r || flags !== vecs[i].f) begin
        n_fail++;
        $display("FAIL directed[%0d]: got %h/%b want %h/%b",
                 i, result, flags, vecs[i].r, vecs[i].f);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] xi, yi, zi, er;
    logic [3:0]  ef;
    logic        mi, ai, npi, nzi;
    logic [1:0]  rm;
    for (int i = 0; i < 1500; i++) begin
      random_op(xi, yi, zi, mi, ai, npi, nzi, rm);
      drive(xi, yi, zi, mi, ai, npi, nzi, rm);
      #1;
      model(xi, yi, zi, mi, ai, npi, nzi, rm, er, ef);
      n_tests++;
      if (result !== er || flags !== ef) begin
        n_fail++;
        $display("FAIL random[%0d] x=%h y=%h z=%h mul=%b add=%b negp=%b negz=%b rm=%b: got %h/%b want %h/%b",
                 i, xi, yi, zi, mi, ai, npi, nzi, rm, result, flags, er, ef);
      end
    end
  endtask

  task automatic check_sticky(input string name, input logic [3:0] want);
    n_tests++;
    if (flags_sticky !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, flags_sticky, want);
    end
  endtask

  task automatic test_sticky();
    @(negedge clk);
    reset = 1'b1;
    drive(16'h7bff, 16'h7bff, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check_sticky("sticky_overflow", 4'b0101);
    @(negedge clk);
    drive(16'h3c00, 16'h3c00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    @(posedge clk); #1;
    check_sticky("sticky_hold", 4'b0101);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_sticky("sticky_async_clear", 4'b0000);
    reset = 1'b0;
    drive(16'h3c01, 16'h3c01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    #1;
    check_sticky("sticky_after_release", 4'b0000);
    @(posedge clk); #1;
    check_sticky("sticky_resume", 4'b0001);
  endtask

  task automatic test_back_to_back();
    logic [15:0] xi, yi, zi, er;
    logic [3:0]  ef, exp_sticky;
    logic        mi, ai, npi, nzi;
    logic [1:0]  rm;
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    exp_sticky = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      random_op(xi, yi, zi, mi, ai, npi, nzi, rm);
      drive(xi, yi, zi, mi, ai, npi, nzi, rm);
      #1;
      model(xi, yi, zi, mi, ai, npi, nzi, rm, er, ef);
      n_tests++;
      if (result !== er || flags !== ef) begin
        n_fail++;
        $display("FAIL b2b[%0d] x=%h y=%h z=%h: got %h/%b want %h/%b",
                 i, xi, yi, zi, result, flags, er, ef);
      end
      exp_sticky = exp_sticky | ef;
      @(posedge clk); #1;
      n_tests++;
      if (flags_sticky !== exp_sticky) begin
        n_fail++;
        $display("FAIL b2b_sticky[%0d]: got %b want %b", i, flags_sticky, exp_sticky);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_sticky();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fma16.md
Name: fma16

Overview:
- Fused multiply-add for IEEE 754 binary16 (half precision).
- Computes ±(x·y) ± z with a single rounding, under one of four rounding modes, and raises the IEEE exception flags.
- The arithmetic path is purely combinational. The one clock and asynchronous reset drive only a sticky accumulated-flags register.
- Sits as the half-precision FP execution unit behind a decoder that supplies the operation controls.

Parameters:
- None.

Ports:
- clk  input  1  system clock; clocks the sticky flag register only
- reset  input  1  asynchronous, active-high; clears flags_sticky
- x  input  16  multiplicand, binary16
- y  input  16  multiplier, binary16
- z  input  16  addend, binary16
- mul  input  1  1: use y; 0: y treated as +1.0 (0x3c00)
- add  input  1  1: use z; 0: no addend (result is the rounded product)
- negp  input  1  negate product
- negz  input  1  negate addend
- roundmode  input  2  00 toward zero, 01 nearest-even, 10 toward −inf, 11 toward +inf
- result  output  16  rounded binary16 result, combinational
- flags  output  4  {invalid, overflow, underflow, inexact} for the current operation, combinational
- flags_sticky  output  4  bitwise OR of flags since reset, registered

Behaviour:
- Operation: result = round((−1)^negp·x·y' + (−1)^negz·z'), where y' = mul ? y : +1.0.
  - add=1: z' = z.
  - add=0: the result is exactly round((−1)^negp·x·y'); the addend never affects sign or value.
- Single rounding on the exact product-plus-sum. The product is kept at full 22-bit significand width, and alignment keeps guard/round/sticky information.
- Subnormal inputs and subnormal outputs are fully supported.
- NaN handling:
  - Any NaN input gives result 0x7e00 (canonical quiet NaN).
  - A signaling NaN input (exp=1F, frac≠0, frac[9]=0) sets invalid.
- Invalid operations: inf·0, and inf + (−inf) after the negations are applied. Each gives 0x7e00 with invalid=1.
- Infinities: an infinite operand otherwise propagates an exact infinity with the correct sign. No flags are raised.
- Exact zero result:
  - Operands of like sign give that sign.
  - Exact cancellation gives +0, except roundmode=10 gives −0.
- Overflow (rounded magnitude > 0x7bff): sets overflow=1 and inexact=1. Result by mode:
  - RNE: ±inf.
  - RZ: ±0x7bff.
  - RD: +0x7bff for positive results, −inf for negative.
  - RU: +inf for positive results, −0x7bff (0xfbff) for negative.
- Underflow flag: set when the result is tiny after rounding (|r| < 2^−14) AND inexact.
- Inexact flag: set whenever the rounded result differs from the exact value.
- flags is 0000 for exact finite results and for quiet-NaN propagation.
- Timing: result and flags settle combinationally with no latency; inputs may change every cycle.
- flags_sticky:
  - On each rising clk it loads flags_sticky | flags.
  - reset=1 clears it to 0000 immediately, regardless of clk.
  - After reset deasserts, accumulation resumes on the next rising edge.

Test Plan:
- x=3c00, y=3c00, mul=1, add=0, RNE → result 3c00, flags 0000. Same with negp=1 → bc00, flags 0000.
- x=4000, y=4200, z=3c00, mul=1, add=1, RNE → 4700 (7.0), flags 0000. Same with negz=1 → 4500 (5.0).
- x=3c01, y=3c01, add=0:
  - RNE → 3c02, flags 0001.
  - RU → 3c03, flags 0001.
  - RZ → 3c02, flags 0001.
- x=7bff, y=7bff, add=0:
  - RNE → 7c00, flags 0101.
  - RZ → 7bff, flags 0101.
  - negp=1, RU → fbff, flags 0101.
- Specials:
  - x=7c00, y=0000 → 7e00, flags 1000.
  - x=7c00, y=3c00, z=fc00, add=1 → 7e00, flags 1000.
  - x=7e00 (any y, z) → 7e00, flags 0000.
  - x=3c00, y=3c00, z=bc00, add=1: RNE → 0000, RD → 8000, flags 0000.
- Sticky flags:
  - Apply the overflow vector, clock once → flags_sticky=0101.
  - Apply an exact vector, clock → flags_sticky stays 0101.
  - Assert reset between edges → flags_sticky=0000 at once.
